// File: rtl/pre_alloc_pkg.sv
// Shared types and width helpers for the multi-entry pre-allocator.
// Default-configuration types; parametrised modules derive their own widths.
package pre_alloc_pkg;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ENTRY_NUM_DEF = 32;
  localparam int ALLOC_NUM_DEF = 2;
  localparam int DEPTH_DEF     = 4;
  localparam int ID_W          = id_width(ENTRY_NUM_DEF);
  localparam int PTR_WIDTH     = $clog2(DEPTH_DEF);

  typedef logic [ID_W-1:0] entry_id_t;
  typedef entry_id_t [ALLOC_NUM_DEF-1:0] alloc_grp_t;

endpackage

// File: rtl/cmn_lead_n.sv
// Finds the ALLOC_NUM lowest set bits of a vector: one cascaded priority
// stage per pick, each stage seeing the vector with earlier picks removed.
module cmn_lead_n #(
  parameter int ENTRY_NUM = 32,
  parameter int ALLOC_NUM = 2,
  parameter int ID_W      = $clog2(ENTRY_NUM)
) (
  input  logic [ENTRY_NUM-1:0]      i_vld,
  output logic [ENTRY_NUM-1:0]      o_mask,
  output logic [ALLOC_NUM*ID_W-1:0] o_ids,
  output logic                      o_ok
);

  logic [ALLOC_NUM:0][ENTRY_NUM-1:0] w_rem;
  logic [ALLOC_NUM-1:0]              w_found;

  assign w_rem[0] = i_vld;

  for (genvar k = 0; k < ALLOC_NUM; k++) begin : g_stage
    logic [ENTRY_NUM-1:0] w_pick;
    logic [ID_W-1:0]      w_id;

    // x & -x isolates the lowest remaining set bit
    assign w_pick       = w_rem[k] & (~w_rem[k] + ENTRY_NUM'(1));
    assign w_rem[k+1]   = w_rem[k] & ~w_pick;
    assign w_found[k]   = |w_rem[k];

    always_comb begin
      w_id = '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (w_pick[i]) w_id = w_id | ID_W'(i);
      end
    end

    assign o_ids[k*ID_W +: ID_W] = w_id;
  end

  assign o_mask = w_rem[0] & ~w_rem[ALLOC_NUM];
  assign o_ok   = &w_found;

endmodule

// File: rtl/pre_alloc_multi.sv
// Reserves groups of ALLOC_NUM free entry IDs into a DEPTH-group ring buffer.
// Optional PRE_ALLOC_BYPASS_EN presents the finder group directly when empty.
module pre_alloc_multi
  import pre_alloc_pkg::*;
#(
  parameter int ENTRY_NUM      = 32,
  parameter int ENTRY_ID_WIDTH = id_width(ENTRY_NUM),
  parameter int ALLOC_NUM      = 2,
  parameter int DEPTH          = 4,
  parameter int CNT_WIDTH      = $clog2(DEPTH+1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ENTRY_NUM-1:0]                v_in_vld,
  output logic [ENTRY_NUM-1:0]                v_in_rdy,
  input  logic                                flush,
  output logic                                out_vld,
  input  logic                                out_rdy,
  output logic [ALLOC_NUM*ENTRY_ID_WIDTH-1:0] out_index,
  output logic [CNT_WIDTH-1:0]                occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int GW = ALLOC_NUM * ENTRY_ID_WIDTH;

  logic [ENTRY_NUM-1:0] w_mask;
  logic [GW-1:0]        w_ids;
  logic                 w_ok;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_byp;
  logic                 w_asc;

  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [GW-1:0]        r_mem [DEPTH];

  cmn_lead_n #(
    .ENTRY_NUM (ENTRY_NUM),
    .ALLOC_NUM (ALLOC_NUM),
    .ID_W      (ENTRY_ID_WIDTH)
  ) u_find (
    .i_vld  (v_in_vld),
    .o_mask (w_mask),
    .o_ids  (w_ids),
    .o_ok   (w_ok)
  );

  assign w_full  = (r_cnt == CNT_WIDTH'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_pop   = !w_empty && out_rdy && !flush;

`ifdef PRE_ALLOC_BYPASS_EN
  assign w_byp     = w_empty && w_ok && out_rdy && !flush && !rst;
  assign out_vld   = !w_empty || w_byp;
  assign out_index = w_byp ? w_ids : (w_empty ? '0 : r_mem[r_rd_ptr]);
`else
  assign w_byp     = 1'b0;
  assign out_vld   = !w_empty;
  assign out_index = w_empty ? '0 : r_mem[r_rd_ptr];
`endif

  // Full blocks push even when a pop frees a slot this cycle
  assign w_push    = w_ok && !w_full && !flush && !rst && !w_byp;
  assign v_in_rdy  = (w_push || w_byp) ? w_mask : '0;
  assign occupancy = r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_WIDTH'(1);
        2'b01:   r_cnt <= r_cnt - CNT_WIDTH'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_ids;
  end

  always_comb begin
    w_asc = 1'b1;
    for (int k = 1; k < ALLOC_NUM; k++) begin
      if (out_index[k*ENTRY_ID_WIDTH +: ENTRY_ID_WIDTH] <=
          out_index[(k-1)*ENTRY_ID_WIDTH +: ENTRY_ID_WIDTH]) w_asc = 1'b0;
    end
  end

  a_asc:  assert property (@(posedge clk) disable iff (rst) out_vld |-> w_asc);
  a_rdy:  assert property (@(posedge clk) disable iff (rst) (v_in_rdy & ~v_in_vld) == '0);
  a_cnt:  assert property (@(posedge clk) disable iff (rst) r_cnt <= CNT_WIDTH'(DEPTH));

endmodule

// File: tb/tb_pre_alloc_multi.sv
// Bench for pre_alloc_multi: directed vector table, async-reset sequence and
// randomized traffic against a queue-of-groups reference model.
module tb_pre_alloc_multi;
  import pre_alloc_pkg::*;

  localparam int EN = 32;
  localparam int AN = 2;
  localparam int DP = 4;
  localparam int IW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [EN-1:0]   v_in_vld;
  logic [EN-1:0]   v_in_rdy;
  logic            flush;
  logic            out_vld;
  logic            out_rdy;
  logic [AN*IW-1:0] out_index;
  logic [2:0]      occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  pre_alloc_multi #(
    .ENTRY_NUM (EN),
    .ALLOC_NUM (AN),
    .DEPTH     (DP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .v_in_vld  (v_in_vld),
    .v_in_rdy  (v_in_rdy),
    .flush     (flush),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_index (out_index),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] grp(input int a, input int b);
    alloc_grp_t g;
    g[0] = entry_id_t'(a);
    g[1] = entry_id_t'(b);
    return 32'(g);
  endfunction

  // Reference: lowest AN free IDs ascending, packed slot0 in the low bits
  function automatic void find(input logic [EN-1:0] v, output bit ok,
                               output logic [EN-1:0] mask, output logic [AN*IW-1:0] idx);
    int n;
    n = 0; mask = '0; idx = '0;
    for (int i = 0; i < EN; i++) begin
      if (v[i] && n < AN) begin
        idx[n*IW +: IW] = IW'(i);
        mask[i] = 1'b1;
        n++;
      end
    end
    ok = ($countones(v) >= AN);
  endfunction

  typedef struct {
    logic [31:0] vld;
    bit          ordy;
    bit          fl;
    logic [31:0] e_rdy;
    bit          e_ov;
    logic [31:0] e_idx;
    int          e_occ;
  } row_t;

  row_t tab[$];
  logic [AN*IW-1:0] q[$];

  task automatic drive(input logic [31:0] v, input bit r, input bit f);
    @(posedge clk);
    #1;
    v_in_vld = v;
    out_rdy  = r;
    flush    = f;
  endtask

  initial begin
    bit               ok, e_ov, byp;
    logic [EN-1:0]    mask, e_rdy, v;
    logic [AN*IW-1:0] fidx, e_idx;
    bit               r, f;

    tab.push_back('{32'h100,      0, 0, 32'h0,  0, 0,          0});
    tab.push_back('{32'h100,      0, 0, 32'h0,  0, 0,          0});
    tab.push_back('{32'h0,        0, 0, 32'h0,  0, 0,          0});
    tab.push_back('{32'hF0,       0, 0, 32'h30, 0, 0,          0});
    tab.push_back('{32'h0,        0, 0, 32'h0,  1, grp(4, 5),  1});
    tab.push_back('{32'h0,        1, 0, 32'h0,  1, grp(4, 5),  1});
    tab.push_back('{32'h0,        0, 0, 32'h0,  0, 0,          0});
    tab.push_back('{32'hFFFFFFFF, 0, 0, 32'h3,  0, 0,          0});
    tab.push_back('{32'hFFFFFFFF, 0, 0, 32'h3,  1, grp(0, 1),  1});
    tab.push_back('{32'hFFFFFFFF, 0, 0, 32'h3,  1, grp(0, 1),  2});
    tab.push_back('{32'hFFFFFFFF, 0, 0, 32'h3,  1, grp(0, 1),  3});
    tab.push_back('{32'hFFFFFFFF, 0, 0, 32'h0,  1, grp(0, 1),  4});
    tab.push_back('{32'hFFFFFFFF, 0, 0, 32'h0,  1, grp(0, 1),  4});
    tab.push_back('{32'hFFFFFFFF, 1, 0, 32'h0,  1, grp(0, 1),  4});
    tab.push_back('{32'hFFFFFFFF, 0, 0, 32'h3,  1, grp(0, 1),  3});
    tab.push_back('{32'h0,        1, 0, 32'h0,  1, grp(0, 1),  4});
    tab.push_back('{32'hFFFFFFFF, 1, 1, 32'h0,  1, grp(0, 1),  3});
    tab.push_back('{32'h0,        0, 0, 32'h0,  0, 0,          0});
    tab.push_back('{32'hC,        0, 0, 32'hC,  0, 0,          0});
    tab.push_back('{32'h30,       1, 0, 32'h30, 1, grp(2, 3),  1});
    tab.push_back('{32'h0,        0, 0, 32'h0,  1, grp(4, 5),  1});
    tab.push_back('{32'h0,        1, 0, 32'h0,  1, grp(4, 5),  1});
    tab.push_back('{32'h0,        0, 0, 32'h0,  0, 0,          0});

    rst = 1'b1; v_in_vld = '1; out_rdy = 1'b0; flush = 1'b0;
    #12;
    chk("reset_rdy", v_in_rdy, 32'h0);
    chk("reset_ovld", 32'(out_vld), 32'h0);
    chk("reset_idx", 32'(out_index), 32'h0);
    chk("reset_occ", 32'(occupancy), 32'h0);
    v_in_vld = '0;
    @(negedge clk);
    rst = 1'b0;

    foreach (tab[i]) begin
      drive(tab[i].vld, tab[i].ordy, tab[i].fl);
      @(negedge clk);
      chk($sformatf("tab%0d_rdy", i), v_in_rdy, tab[i].e_rdy);
      chk($sformatf("tab%0d_ovld", i), 32'(out_vld), 32'(tab[i].e_ov));
      chk($sformatf("tab%0d_idx", i), 32'(out_index), tab[i].e_idx);
      chk($sformatf("tab%0d_occ", i), 32'(occupancy), 32'(tab[i].e_occ));
    end

    drive(32'hF0, 0, 0);
    drive(32'hF00, 0, 0);
    drive(32'h0, 0, 0);
    @(negedge clk);
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    @(posedge clk);
    #3;
    rst = 1'b1;
    v_in_vld = '1;
    #1;
    chk("async_rst_ovld", 32'(out_vld), 32'h0);
    chk("async_rst_occ", 32'(occupancy), 32'h0);
    chk("async_rst_idx", 32'(out_index), 32'h0);
    chk("async_rst_rdy", v_in_rdy, 32'h0);
    v_in_vld = '0;
    @(negedge clk);
    rst = 1'b0;

    q.delete();
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 3))
        0:       v = '0;
        1:       v = 32'(1) << $urandom_range(0, 31);
        2:       v = $urandom & $urandom & $urandom;
        default: v = $urandom;
      endcase
      r = ($urandom_range(0, 1) == 1);
      f = ($urandom_range(0, 31) == 0);
      drive(v, r, f);
      @(negedge clk);

      find(v, ok, mask, fidx);
      e_ov  = (q.size() != 0);
      e_idx = e_ov ? q[0] : '0;
      byp   = 1'b0;
`ifdef PRE_ALLOC_BYPASS_EN
      if (q.size() == 0 && ok && r && !f) begin
        byp = 1'b1; e_ov = 1'b1; e_idx = fidx;
      end
`endif
      e_rdy = ((ok && q.size() < DP && !f) || byp) ? mask : '0;
      chk("rnd_rdy", v_in_rdy, e_rdy);
      chk("rnd_ovld", 32'(out_vld), 32'(e_ov));
      chk("rnd_idx", 32'(out_index), 32'(e_idx));
      chk("rnd_occ", 32'(occupancy), 32'(q.size()));

      if (f) q.delete();
      else if (!byp) begin
        if (q.size() != 0 && r) void'(q.pop_front());
        if (e_rdy != '0) q.push_back(fidx);
      end
    end

    drive('0, 0, 1);
    drive('0, 0, 0);
    @(negedge clk);
    chk("flush_empty_occ", 32'(occupancy), 32'h0);

`ifdef PRE_ALLOC_BYPASS_EN
    drive(32'h6, 1, 0);
    @(negedge clk);
    chk("byp_ovld", 32'(out_vld), 32'h1);
    chk("byp_idx", 32'(out_index), grp(1, 2));
    chk("byp_rdy", v_in_rdy, 32'h6);
    chk("byp_occ", 32'(occupancy), 32'h0);
    drive(32'h0, 0, 0);
    @(negedge clk);
    chk("byp_after_occ", 32'(occupancy), 32'h0);
    chk("byp_after_ovld", 32'(out_vld), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
